imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  - Write-side companion of the instruction memory: receives a byte-stream program image and
//    writes it word by word into the IMEM write port.
//  - Holds the CPU in reset (cpu_hold) until the image is fully loaded.
//  - Sits between a byte source (UART RX, test harness) and the IMEM write port.
// PARAMETERS
//  - IMEM_SIZE  1024           capacity in 32-bit words; a larger header count is an error
//  - BASE_ADDR  32'h0000_0000  byte address of the first word written; word-aligned
// PORTS
//  - clk           in   1            system clock; all logic on rising edge
//  - rst_n         in   1            asynchronous active-low reset
//  - in_data       in   8            stream byte
//  - in_valid      in   1            in_data valid
//  - in_ready      out  1            loader accepts a byte; transfer = in_valid & in_ready
//  - start         in   1            one-cycle pulse; restarts a load from DONE/ERR
//  - imem_we       out  1            one-cycle IMEM write strobe
//  - imem_addr     out  `ADDR_LEN    byte address of the write (bits [1:0] = 0)
//  - imem_wdata    out  `INSTR_LEN   instruction word to write
//  - words_loaded  out  32           words written in the current load
//  - done          out  1            load complete; held until start or reset
//  - error         out  1            load aborted; held until start or reset
//  - cpu_hold      out  1            high = keep CPU in reset
// BEHAVIOUR
//  - Reset values: state=HDR, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, words_loaded=0,
//    done=0, error=0, cpu_hold=1, byte counter=0. IMEM contents are not cleared.
//  - in_ready is combinational: 1 in HDR, DATA and CHK; 0 in DONE and ERR.
//  - Byte order is little-endian: the first byte goes to [7:0] and the 4th byte to [31:24],
//    for both the header and data words.
//  - HDR: collect 4 bytes into the 32-bit word count N. On the 4th byte:
//      - N == 0          -> DONE (or CHK when the checksum option is enabled)
//      - N > IMEM_SIZE   -> ERR
//      - otherwise       -> DATA
//  - DATA: assemble 4 bytes per word. The cycle after the 4th byte is accepted:
//      - imem_we=1 for exactly one cycle
//      - imem_addr = BASE_ADDR + 4*words_loaded (pre-increment value)
//      - imem_wdata = assembled word
//      - words_loaded increments in that same cycle
//    Write latency is 1 cycle. in_ready stays high, so the next word's bytes can stream
//    back-to-back with no conflict. Outside write cycles imem_addr/imem_wdata hold their values.
//  - Entering DONE after the last write: done=1 and cpu_hold=0 in the cycle after that write.
//  - ERR: error=1, cpu_hold stays 1, no further writes.
//  - start in DONE/ERR -> HDR next cycle: clears done, error, words_loaded and the byte
//    counter; cpu_hold=1; imem_addr=BASE_ADDR.
//  - start in HDR/DATA/CHK is ignored.
//  - start and in_valid in the same cycle in DONE/ERR: start wins; the byte is not accepted
//    (in_ready=0).
//  - in_valid low mid-word: the partial word is held indefinitely; no timeout.
//  - The 32-bit address sum wraps modulo 2^32, which cannot occur when N <= IMEM_SIZE and
//    BASE_ADDR is in range.
//  - rst_n asserted mid-load: immediate return to reset values. Words already written remain
//    in IMEM; a partially assembled word is discarded.
// CONFIGURATION
//  - IMEM_LOADER_CHECKSUM_EN defined:
//      - after the N data words (or directly after a zero count) the loader enters CHK and
//        takes 1 extra byte
//      - the running XOR over all data bytes is compared with it: match -> DONE,
//        mismatch -> ERR
//      - header bytes are excluded from the XOR
//  - Undefined: no CHK state; DATA (or HDR when N==0) goes directly to DONE.
// TESTING
//  - Reset, then N=2, words 0x20080005, 0x00000000:
//    - imem_we pulses at addr 0x0 and 0x4 with those words
//    - done=1, cpu_hold=0, words_loaded=2
//  - Header N=1025 with IMEM_SIZE=1024 -> error=1, cpu_hold=1, no imem_we pulse, in_ready=0.
//  - Header N=0 -> done=1 one cycle after the 4th header byte, no writes
//    (checksum build: byte 0x00 also required).
//  - in_valid toggled every other cycle mid-word -> word assembled correctly; write exactly
//    1 cycle after the 4th accepted byte.
//  - rst_n pulsed low after 2 bytes of word 1, then a full image with N=1 ->
//    only the new word is written, at addr 0x0.
//  - Checksum build: N=1, word 0x11223344, check byte 0x44 -> done=1;
//    check byte 0x45 -> error=1, cpu_hold=1; then start -> HDR, in_ready=1.

Source files
------------

// File: rtl/imem_loader_if.sv
// ----------------------------------------------------------------------------
// imem_loader_if
//   Groups the byte-stream input and the IMEM write port of imem_loader.
//   Ports (signals):
//     in_data    [7:0]            stream byte
//     in_valid                    in_data valid
//     in_ready                    loader accepts a byte (in_valid & in_ready)
//     imem_we                     one-cycle IMEM write strobe
//     imem_addr  [`ADDR_LEN-1:0]  byte address of the write
//     imem_wdata [`INSTR_LEN-1:0] instruction word to write
//   Modports:
//     master : byte source / IMEM side (drives the stream, observes writes)
//     slave  : the loader itself
// ----------------------------------------------------------------------------
`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

interface imem_loader_if;
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  imem_we;
    logic [`ADDR_LEN-1:0]  imem_addr;
    logic [`INSTR_LEN-1:0] imem_wdata;

    modport master (
        output in_data, in_valid,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// ----------------------------------------------------------------------------
// imem_loader
//   Receives a little-endian byte-stream program image (32-bit word count N
//   followed by N words) and writes it word by word into the IMEM write port.
//   Holds the CPU in reset (cpu_hold) until the image is completely loaded.
//   Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR check
//   byte over all data bytes (header excluded).
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset
//     bus (slave)    in_data/in_valid/in_ready stream, imem_we/addr/wdata
//     start          one-cycle pulse, restarts a load from DONE/ERR
//     words_loaded   words written in the current load
//     done, error    sticky load status, cleared by start or reset
//     cpu_hold       high keeps the CPU in reset
// ----------------------------------------------------------------------------
module imem_loader #(
    parameter int unsigned IMEM_SIZE = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    imem_loader_if.slave      bus,
    input  logic              start,
    output logic [31:0]       words_loaded,
    output logic              done,
    output logic              error,
    output logic              cpu_hold
);

    typedef enum logic [2:0] {
        ST_HDR,
        ST_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHK,
`endif
        ST_DONE,
        ST_ERR
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] shift_q, shift_d;     // bytes 0..2 of the word being assembled
    logic [31:0] count_q, count_d;
    logic [31:0] words_q, words_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        hold_q, hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  xor_q, xor_d;
`endif

    logic        in_ready;
    logic        accept;
    logic [31:0] word_full;

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign in_ready = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_CHK);
`else
    assign in_ready = (state_q == ST_HDR) || (state_q == ST_DATA);
`endif
    assign accept    = bus.in_valid & in_ready;
    assign word_full = {bus.in_data, shift_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        count_d = count_q;
        words_d = words_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        error_d = error_q;
        hold_d  = hold_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_d   = xor_q;
`endif
        case (state_q)
            ST_HDR: begin
                if (accept) begin
                    shift_d = {bus.in_data, shift_q[23:8]};
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        count_d = word_full;
                        if (word_full == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_d = ST_CHK;
`else
                            // Empty image: status goes up together with the state change.
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            hold_d  = 1'b0;
`endif
                        end else if (word_full > 32'(IMEM_SIZE)) begin
                            state_d = ST_ERR;
                            error_d = 1'b1;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    shift_d = {bus.in_data, shift_q[23:8]};
                    cnt_d   = cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_d   = xor_q ^ bus.in_data;
`endif
                    if (cnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = BASE_ADDR + (words_q << 2);
                        wdata_d = word_full;
                        words_d = words_q + 32'd1;
                        // Leaving DATA on the last word; done rises one cycle after
                        // the write because the DONE state raises it itself.
                        if (words_q + 32'd1 == count_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_d = ST_CHK;
`else
                            state_d = ST_DONE;
`endif
                        end
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (accept) begin
                    if (bus.in_data == xor_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                    end
                end
            end
`endif
            ST_DONE: begin
                done_d = 1'b1;
                hold_d = 1'b0;
            end
            ST_ERR: begin
                error_d = 1'b1;
            end
            default: state_d = ST_HDR;
        endcase

        // Restart has priority over the status-holding defaults of DONE/ERR.
        if (start && (state_q == ST_DONE || state_q == ST_ERR)) begin
            state_d = ST_HDR;
            cnt_d   = '0;
            words_d = '0;
            addr_d  = BASE_ADDR;
            done_d  = 1'b0;
            error_d = 1'b0;
            hold_d  = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_d   = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HDR;
            cnt_q   <= '0;
            shift_q <= '0;
            count_q <= '0;
            words_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            wdata_q <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            hold_q  <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            count_q <= count_d;
            words_q <= words_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            error_q <= error_d;
            hold_q  <= hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q   <= xor_d;
`endif
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign words_loaded   = words_q;
    assign done           = done_q;
    assign error          = error_q;
    assign cpu_hold       = hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// ----------------------------------------------------------------------------
// tb_imem_loader
//   Directed bench for imem_loader. Expected IMEM writes (address, word and
//   the cycle they must appear in) are queued when the last byte of a word is
//   offered; a negedge monitor pops and compares every imem_we pulse.
// ----------------------------------------------------------------------------
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] words_loaded;
    logic        done, error, cpu_hold;

    imem_loader_if bus();

    imem_loader #(.IMEM_SIZE(1024), .BASE_ADDR(32'h0000_0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .start        (start),
        .words_loaded (words_loaded),
        .done         (done),
        .error        (error),
        .cpu_hold     (cpu_hold)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int unsigned cyc;
    } wr_t;
    wr_t exp_q[$];

    int errors = 0;
    int checks = 0;
    logic [7:0] xsum;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Write monitor / scoreboard
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %h data %h, no write expected", bus.imem_addr, bus.imem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", bus.imem_addr, e.addr);
                check("wr_data", bus.imem_wdata, e.data);
                check("wr_cycle", cyc, e.cyc);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the byte was accepted.
    task automatic send_byte(input logic [7:0] b, input bit push, input logic [31:0] a, input logic [31:0] d);
        int n;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: byte %h not accepted within 50 cycles", b);
            bus.in_valid = 1'b0;
        end else begin
            if (push) exp_q.push_back('{a, d, cyc + 1});
            @(negedge clk);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b0, '0, '0);
    endtask

    task automatic send_data_word(input logic [31:0] w, input logic [31:0] a);
        for (int i = 0; i < 4; i++) begin
            xsum = xsum ^ w[8*i +: 8];
            send_byte(w[8*i +: 8], i == 3, a, w);
        end
    endtask

    task automatic pulse_start();
        bus.in_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        xsum = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] w;
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        xsum = '0;
        repeat (2) @(negedge clk);

        // Reset values
        check("rst_cpu_hold", cpu_hold, 1);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_words", words_loaded, 0);
        check("rst_we", bus.imem_we, 0);
        check("rst_addr", bus.imem_addr, 32'h0);
        check("rst_wdata", bus.imem_wdata, 32'h0);
        check("rst_in_ready", bus.in_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // N=2 image, back-to-back bytes
        send_word(32'd2);
        send_data_word(32'h2008_0005, 32'h0);
        send_data_word(32'h0000_0000, 32'h4);
        check("n2_done_in_write_cycle", done, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h2D, 1'b0, '0, '0);
`endif
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("n2_done", done, 1);
        check("n2_cpu_hold", cpu_hold, 0);
        check("n2_words", words_loaded, 2);
        check("n2_in_ready", bus.in_ready, 0);
        check("n2_pending", exp_q.size(), 0);

        // start together with in_valid in DONE: byte must be dropped
        bus.in_data  = 8'hAA;
        bus.in_valid = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bus.in_valid = 1'b0;
        xsum = '0;
        check("restart_done", done, 0);
        check("restart_hold", cpu_hold, 1);
        check("restart_words", words_loaded, 0);
        check("restart_in_ready", bus.in_ready, 1);
        check("restart_addr", bus.imem_addr, 32'h0);

        // Oversized header
        send_word(32'd1025);
        bus.in_valid = 1'b0;
        check("big_error", error, 1);
        check("big_cpu_hold", cpu_hold, 1);
        check("big_in_ready", bus.in_ready, 0);
        check("big_done", done, 0);
        repeat (3) @(negedge clk);
        pulse_start();
        check("err_restart_error", error, 0);
        check("err_restart_in_ready", bus.in_ready, 1);

        // Empty image
        send_word(32'd0);
        bus.in_valid = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("n0_wait_chk", done, 0);
        send_byte(8'h00, 1'b0, '0, '0);
        bus.in_valid = 1'b0;
`endif
        check("n0_done", done, 1);
        check("n0_cpu_hold", cpu_hold, 0);
        check("n0_words", words_loaded, 0);
        pulse_start();

        // Gapped bytes, with an ignored start mid-word
        send_word(32'd1);
        w = 32'hCAFE_F00D;
        for (int i = 0; i < 4; i++) begin
            xsum = xsum ^ w[8*i +: 8];
            send_byte(w[8*i +: 8], i == 3, 32'h0, w);
            if (i < 3) begin
                bus.in_valid = 1'b0;
                if (i == 1) start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(xsum, 1'b0, '0, '0);
`endif
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("gap_done", done, 1);
        check("gap_words", words_loaded, 1);
        pulse_start();

        // Reset in the middle of word 1
        send_word(32'd2);
        send_byte(8'h11, 1'b0, '0, '0);
        send_byte(8'h22, 1'b0, '0, '0);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_words", words_loaded, 0);
        check("midrst_addr", bus.imem_addr, 32'h0);
        check("midrst_hold", cpu_hold, 1);
        check("midrst_in_ready", bus.in_ready, 1);
        rst_n = 1'b1;
        xsum = '0;
        @(negedge clk);
        send_word(32'd1);
        send_data_word(32'h89AB_CDEF, 32'h0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(xsum, 1'b0, '0, '0);
`endif
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("midrst_done", done, 1);
        check("midrst_words_final", words_loaded, 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum match and mismatch
        pulse_start();
        send_word(32'd1);
        send_data_word(32'h1122_3344, 32'h0);
        send_byte(8'h44, 1'b0, '0, '0);
        bus.in_valid = 1'b0;
        check("chk_ok_done", done, 1);
        check("chk_ok_error", error, 0);
        pulse_start();
        send_word(32'd1);
        send_data_word(32'h1122_3344, 32'h0);
        send_byte(8'h45, 1'b0, '0, '0);
        bus.in_valid = 1'b0;
        check("chk_bad_error", error, 1);
        check("chk_bad_hold", cpu_hold, 1);
        check("chk_bad_done", done, 0);
        pulse_start();
        check("chk_restart_in_ready", bus.in_ready, 1);
        check("chk_restart_error", error, 0);
`endif

        repeat (2) @(negedge clk);
        check("final_pending", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
